// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding, word length and register-index width for the hazard unit
`ifndef HAZARD_CTRL_PKG_SV
`define HAZARD_CTRL_PKG_SV
`define WORD_LEN 32
package hazard_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_LU1   = 3'd1,
        ST_LU2   = 3'd2,
        ST_MWAIT = 3'd3,
        ST_FLUSH = 3'd4
    } hz_state_t;
endpackage
`endif

// File: rtl/hz_sat_counter.sv
// hz_sat_counter: event counter that sticks at all-ones instead of wrapping
module hz_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    // count up on inc, hold once every bit is set
    always_ff @(posedge clk or negedge nReset)
        if (!nReset) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch / memory-wait pipeline interlock; perf counters under HAZARD_PERF_EN
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = hazard_ctrl_pkg::REG_ADDR_W,
    parameter int PERF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_is_branch,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_r_en,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  pc_hold,
    output logic                  if2id_hold,
    output logic                  if2id_flush,
    output logic                  id2exe_flush,
    output logic                  id2exe_stall,
    output logic                  id2exe_stall_twice,
    output logic                  exe2mem_hold,
    output logic                  mem2wb_hold,
`ifdef HAZARD_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt,
    output logic [PERF_CNT_W-1:0] perf_mwait_cnt,
`endif
    output logic [2:0]            state
);
    hz_state_t st, nxt;
    logic twice_q;
    logic hz, mwait;
    assign hz = ex_mem_r_en && ex_rd != '0 &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign mwait = mem_req && !dmem_ready;
    assign state = st;
    // next state and zero-latency outputs; everything forced low while reset is held
    always_comb begin
        pc_hold = 1'b0;
        if2id_hold = 1'b0;
        if2id_flush = 1'b0;
        id2exe_flush = 1'b0;
        id2exe_stall = 1'b0;
        id2exe_stall_twice = 1'b0;
        exe2mem_hold = 1'b0;
        mem2wb_hold = 1'b0;
        nxt = ST_RUN;
        if (nReset)
            unique case (st)
                ST_RUN:
                    if (ex_branch_taken) begin
                        if2id_flush = 1'b1;
                        id2exe_flush = 1'b1;
                        nxt = ST_FLUSH;
                    end else if (mwait) begin
                        pc_hold = 1'b1;
                        if2id_hold = 1'b1;
                        exe2mem_hold = 1'b1;
                        mem2wb_hold = 1'b1;
                        nxt = ST_MWAIT;
                    end else if (hz) begin
                        pc_hold = 1'b1;
                        if2id_hold = 1'b1;
                        id2exe_stall = !id_is_branch;
                        id2exe_stall_twice = id_is_branch;
                        nxt = ST_LU1;
                    end
                ST_LU1:
                    if (ex_branch_taken) begin
                        if2id_flush = 1'b1;
                        id2exe_flush = 1'b1;
                        nxt = ST_FLUSH;
                    end else begin
                        pc_hold = twice_q;
                        if2id_hold = twice_q;
                        nxt = twice_q ? ST_LU2 : ST_RUN;
                    end
                ST_LU2:
                    if (ex_branch_taken) begin
                        if2id_flush = 1'b1;
                        id2exe_flush = 1'b1;
                        nxt = ST_FLUSH;
                    end
                ST_MWAIT: begin
                    pc_hold = !dmem_ready;
                    if2id_hold = !dmem_ready;
                    exe2mem_hold = !dmem_ready;
                    mem2wb_hold = !dmem_ready;
                    nxt = dmem_ready ? ST_RUN : ST_MWAIT;
                end
                default: nxt = ST_RUN;
            endcase
    end
    // state register; twice_q remembers whether the stall that entered LU1 came from a branch
    always_ff @(posedge clk or negedge nReset)
        if (!nReset) begin
            st <= ST_RUN;
            twice_q <= 1'b0;
        end else begin
            st <= nxt;
            twice_q <= (st == ST_RUN) ? id_is_branch : twice_q;
        end
`ifdef HAZARD_PERF_EN
    hz_sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk(clk), .nReset(nReset), .inc(pc_hold), .cnt(perf_stall_cnt));
    hz_sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk(clk), .nReset(nReset), .inc(if2id_flush), .cnt(perf_flush_cnt));
    hz_sat_counter #(.W(PERF_CNT_W)) u_mwait_cnt (
        .clk(clk), .nReset(nReset), .inc(st == ST_MWAIT), .cnt(perf_mwait_cnt));
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of the hazard unit; perf counters checked when HAZARD_PERF_EN is defined
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;
    localparam int AW = 5;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic nReset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, id_is_branch, ex_mem_r_en, ex_branch_taken, mem_req, dmem_ready;
    logic pc_hold, if2id_hold, if2id_flush, id2exe_flush, id2exe_stall, id2exe_stall_twice;
    logic exe2mem_hold, mem2wb_hold;
    logic [2:0] state;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_mwait_cnt;
    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.REG_ADDR_W(AW), .PERF_CNT_W(CW)) dut (
        .clk(clk), .nReset(nReset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch), .ex_rd(ex_rd), .ex_mem_r_en(ex_mem_r_en),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_hold(pc_hold), .if2id_hold(if2id_hold), .if2id_flush(if2id_flush),
        .id2exe_flush(id2exe_flush), .id2exe_stall(id2exe_stall),
        .id2exe_stall_twice(id2exe_stall_twice), .exe2mem_hold(exe2mem_hold),
        .mem2wb_hold(mem2wb_hold),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_mwait_cnt(perf_mwait_cnt),
`endif
        .state(state)
    );

`ifndef HAZARD_PERF_EN
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
    assign perf_mwait_cnt = '0;
`endif

    always #5 clk = ~clk;

    // outputs packed as {pc_hold,if2id_hold,if2id_flush,id2exe_flush,stall,stall_twice,exe2mem,mem2wb}
    task automatic ck(input string tag, input logic [7:0] exp_o, input logic [2:0] exp_s);
        logic [10:0] obs, exp;
        #1;
        obs = {pc_hold, if2id_hold, if2id_flush, id2exe_flush, id2exe_stall, id2exe_stall_twice,
               exe2mem_hold, mem2wb_hold, state};
        exp = {exp_o, exp_s};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: outs/state observed %b/%0d expected %b/%0d", tag, obs[10:3], obs[2:0],
                   exp[10:3], exp[2:0]);
        end
    endtask

    task automatic ckc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_is_branch = 0; ex_mem_r_en = 0;
        ex_branch_taken = 0; mem_req = 0; dmem_ready = 1;
    endtask

    task automatic load_use(input logic [AW-1:0] r, input logic via_rs2, input logic br);
        idle();
        ex_mem_r_en = 1; ex_rd = r; id_is_branch = br;
        if (via_rs2) begin id_rs2 = r; id_use_rs2 = 1; end
        else begin id_rs1 = r; id_use_rs1 = 1; end
    endtask

    initial begin
        nReset = 0;
        load_use(5'd5, 0, 0);
        mem_req = 1; dmem_ready = 0;
        ck("reset_outputs", 8'b0, ST_RUN);
        cyc();
        ck("reset_held", 8'b0, ST_RUN);
        ckc("reset_stall_cnt", perf_stall_cnt, 0);
        ckc("reset_mwait_cnt", perf_mwait_cnt, 0);
        nReset = 1;
        idle();
        ck("idle", 8'b0, ST_RUN);
        load_use(5'd5, 0, 0);
        ck("lu_run", 8'b1100_1000, ST_RUN);
        cyc();
        ck("lu_lu1_no_reeval", 8'b0, ST_LU1);
        cyc();
        idle();
        ck("lu_back", 8'b0, ST_RUN);
        load_use(5'd7, 1, 1);
        ck("lub_run", 8'b1100_0100, ST_RUN);
        cyc();
        ck("lub_lu1", 8'b1100_0000, ST_LU1);
        cyc();
        ck("lub_lu2", 8'b0, ST_LU2);
        cyc();
        idle();
        ck("lub_back", 8'b0, ST_RUN);
        load_use(5'd0, 0, 0);
        ck("x0_no_stall", 8'b0, ST_RUN);
        load_use(5'd5, 0, 0);
        id_use_rs1 = 0;
        ck("unused_src_no_stall", 8'b0, ST_RUN);
        idle();
        mem_req = 1; dmem_ready = 0;
        ck("mw_run", 8'b1100_0011, ST_RUN);
        cyc();
        ck("mw_1", 8'b1100_0011, ST_MWAIT);
        cyc();
        ck("mw_2", 8'b1100_0011, ST_MWAIT);
        cyc();
        dmem_ready = 1;
        ck("mw_ready", 8'b0, ST_MWAIT);
        cyc();
        idle();
        ck("mw_back", 8'b0, ST_RUN);
        load_use(5'd5, 0, 0);
        mem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
        ck("br_wins", 8'b0011_0000, ST_RUN);
        cyc();
        ck("br_flush_quiet", 8'b0, ST_FLUSH);
        cyc();
        idle();
        ck("br_back", 8'b0, ST_RUN);
        load_use(5'd9, 0, 1);
        cyc();
        idle();
        ex_branch_taken = 1;
        ck("lu1_abort", 8'b0011_0000, ST_LU1);
        cyc();
        idle();
        ck("abort_flush", 8'b0, ST_FLUSH);
        cyc();
        ck("abort_back", 8'b0, ST_RUN);
        load_use(5'd3, 1, 1);
        cyc(2);
        load_use(5'd3, 1, 1);
        nReset = 0;
        ck("rst_in_lu2", 8'b0, ST_RUN);
        cyc();
        nReset = 1;
        ck("rst_lu2_release", 8'b1100_0100, ST_RUN);
        idle();
        ck("rst_lu2_no_residual", 8'b0, ST_RUN);
        mem_req = 1; dmem_ready = 0;
        cyc();
        nReset = 0;
        ck("rst_in_mwait", 8'b0, ST_RUN);
        ckc("rst_clr_stall_cnt", perf_stall_cnt, 0);
        ckc("rst_clr_flush_cnt", perf_flush_cnt, 0);
        cyc();
        idle();
        nReset = 1;
        ck("rst_mwait_no_residual", 8'b0, ST_RUN);
        cyc();
        ck("rst_mwait_stays_run", 8'b0, ST_RUN);
`ifdef HAZARD_PERF_EN
        ex_branch_taken = 1;
        cyc();
        idle();
        cyc();
        ckc("perf_flush_one", perf_flush_cnt, 1);
        ckc("perf_stall_zero", perf_stall_cnt, 0);
        mem_req = 1; dmem_ready = 0;
        cyc(5);
        ckc("perf_stall_5", perf_stall_cnt, 5);
        ckc("perf_mwait_4", perf_mwait_cnt, 4);
        cyc(15);
        ckc("perf_stall_sat", perf_stall_cnt, 4'hF);
        ckc("perf_mwait_sat", perf_mwait_cnt, 4'hF);
        idle();
        cyc(2);
        ckc("perf_stall_hold_sat", perf_stall_cnt, 4'hF);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
